sdram_responder: RTL and testbench



---
 rtl/sdram_responder_if.sv | 24 ++
 rtl/sdram_responder.sv | 243 ++++++++++++++++++++++++
 tb/tb_sdram_responder.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_responder_if.sv
// SDRAM pin bundle between the team's controller (master) and the device-side responder (slave).
// pin_data_i carries write data toward the device; pin_data_o/pin_data_oe carry read data back.
interface sdram_if #(
   parameter int AW     = 12,
   parameter int DWIDTH = 16
);
   logic              pin_ras_n;
   logic              pin_cas_n;
   logic              pin_we_n;
   logic [AW-1:0]     pin_addr;
   logic [DWIDTH-1:0] pin_data_i;
   logic [DWIDTH-1:0] pin_data_o;
   logic              pin_data_oe;

   modport master (
      output pin_ras_n, pin_cas_n, pin_we_n, pin_addr, pin_data_i,
      input  pin_data_o, pin_data_oe
   );

   modport slave (
      input  pin_ras_n, pin_cas_n, pin_we_n, pin_addr, pin_data_i,
      output pin_data_o, pin_data_oe
   );
endinterface

// File: rtl/sdram_responder.sv
// SDRAM device-side responder: command decode, bank/mode tracking, CL-delayed reads, timing checks.
// Optional refresh-interval check enabled by defining SDRAM_RESP_REFRESH_CHECK_EN.
module sdram_responder #(
   parameter int BANKBITS = 1,
   parameter int ROWBITS  = 11,
   parameter int COLBITS  = 8,
   parameter int DWIDTH   = 16,
   parameter int MEMBITS  = 10,
   parameter int T_RCD    = 3,
   parameter int T_RP     = 3,
   parameter int T_RC     = 8,
   parameter int T_MRD    = 3
`ifdef SDRAM_RESP_REFRESH_CHECK_EN
   ,
   parameter int T_RI_MAX = 2048
`endif
) (
   input  logic                       clk,
   input  logic                       reset,
   sdram_if.slave                     bus,
   output logic                       err,
   output logic [3:0]                 err_code,
   output logic [(1<<BANKBITS)-1:0]   dbg_bank_active_o
);
   localparam int NB = 1 << BANKBITS;
   localparam int AW = BANKBITS + ROWBITS;
   localparam logic [4:0] RCD5 = 5'(T_RCD);
   localparam logic [4:0] RP5  = 5'(T_RP);
   localparam logic [4:0] RC5  = 5'(T_RC);
   localparam logic [4:0] MRD5 = 5'(T_MRD);

   typedef enum logic [2:0] {
      CMD_MODE = 3'b000, CMD_REF = 3'b001, CMD_PRE  = 3'b010, CMD_ACT = 3'b011,
      CMD_WR   = 3'b100, CMD_RD  = 3'b101, CMD_STOP = 3'b110, CMD_NOP = 3'b111
   } cmd_e;

   typedef enum logic {BANK_IDLE, BANK_ACTIVE} bank_e;

   function automatic logic [4:0] sat_inc(input logic [4:0] c);
      return (c == 5'd31) ? c : c + 5'd1;
   endfunction

   cmd_e                cmd;
   logic [BANKBITS-1:0] ba;
   logic [ROWBITS-1:0]  row;
   logic [COLBITS-1:0]  col;
   logic                a10;

   assign cmd = cmd_e'({bus.pin_ras_n, bus.pin_cas_n, bus.pin_we_n});
   assign ba  = bus.pin_addr[AW-1:ROWBITS];
   assign row = bus.pin_addr[ROWBITS-1:0];
   assign col = bus.pin_addr[COLBITS-1:0];
   assign a10 = bus.pin_addr[10];

   bank_e              bank_q    [NB], bank_d    [NB];
   logic [ROWBITS-1:0] row_q     [NB], row_d     [NB];
   logic [4:0]         act_cnt_q [NB], act_cnt_d [NB];
   logic [4:0]         pre_cnt_q [NB], pre_cnt_d [NB];
   logic [4:0]         mrd_cnt_q, mrd_cnt_d, ref_cnt_q, ref_cnt_d;
   logic               mode_set_q, mode_set_d, cl3_q, cl3_d;
   logic [1:0]         rd_v_q, rd_v_d;
   logic [DWIDTH-1:0]  rd_data_q [2], rd_data_d [2];
   logic [DWIDTH-1:0]  data_o_q, data_o_d;
   logic               oe_q, oe_d, err_q, err_d;
   logic [3:0]         code_q, code_d, first;
   logic [15:0]        viol;
   logic               any_active, any_trp, mem_we;

   logic [DWIDTH-1:0]  mem_q [2**MEMBITS];
   logic [MEMBITS-1:0] mem_idx;
   logic [DWIDTH-1:0]  mem_rd;

   assign mem_idx = MEMBITS'({row_q[ba], ba, col});
   assign mem_rd  = mem_q[mem_idx];

`ifdef SDRAM_RESP_REFRESH_CHECK_EN
   localparam logic [15:0] RI_LAST = 16'(T_RI_MAX - 1);
   logic [15:0] ri_cnt_q, ri_cnt_d;
   logic        ri_run_q, ri_run_d;
`endif

   always_comb begin
      bank_d     = bank_q;
      row_d      = row_q;
      mode_set_d = mode_set_q;
      cl3_d      = cl3_q;
      mrd_cnt_d  = sat_inc(mrd_cnt_q);
      ref_cnt_d  = sat_inc(ref_cnt_q);
      any_active = 1'b0;
      any_trp    = 1'b0;
      for (int b = 0; b < NB; b++) begin
         act_cnt_d[b] = sat_inc(act_cnt_q[b]);
         pre_cnt_d[b] = sat_inc(pre_cnt_q[b]);
         any_active   = any_active | (bank_q[b] == BANK_ACTIVE);
         any_trp      = any_trp | (pre_cnt_q[b] < RP5);
      end
      // Stage 1 feeds stage 0; stage 0 feeds the output register (total latency = CL).
      rd_v_d[0]    = rd_v_q[1];
      rd_data_d[0] = rd_data_q[1];
      rd_v_d[1]    = 1'b0;
      rd_data_d[1] = '0;
      oe_d         = rd_v_q[0];
      data_o_d     = rd_v_q[0] ? rd_data_q[0] : '0;
      mem_we       = 1'b0;
      viol         = '0;

      if (cmd != CMD_NOP && cmd != CMD_STOP && mrd_cnt_q < MRD5) viol[8] = 1'b1;

      case (cmd)
         CMD_MODE: begin
            mrd_cnt_d = 5'd1;
            if ((bus.pin_addr[6:4] == 3'd2 || bus.pin_addr[6:4] == 3'd3) &&
                bus.pin_addr[2:0] == 3'd0) begin
               mode_set_d = 1'b1;
               cl3_d      = bus.pin_addr[4];
            end else begin
               viol[10] = 1'b1;
            end
         end
         CMD_REF: begin
            ref_cnt_d = 5'd1;
            if (any_active)       viol[7] = 1'b1;
            if (any_trp)          viol[5] = 1'b1;
            if (ref_cnt_q < RC5)  viol[6] = 1'b1;
         end
         CMD_PRE: begin
            for (int b = 0; b < NB; b++) begin
               if (a10 || b == int'(ba)) begin
                  bank_d[b]    = BANK_IDLE;
                  pre_cnt_d[b] = 5'd1;
               end
            end
         end
         CMD_ACT: begin
            if (!mode_set_q)                 viol[1] = 1'b1;
            if (bank_q[ba] == BANK_ACTIVE)   viol[4] = 1'b1;
            if (pre_cnt_q[ba] < RP5)         viol[5] = 1'b1;
            if (act_cnt_q[ba] < RC5 || ref_cnt_q < RC5) viol[6] = 1'b1;
            bank_d[ba]    = BANK_ACTIVE;
            row_d[ba]     = row;
            act_cnt_d[ba] = 5'd1;
         end
         CMD_WR, CMD_RD: begin
            if (!mode_set_q)               viol[1]  = 1'b1;
            if (bank_q[ba] == BANK_IDLE)   viol[2]  = 1'b1;
            if (act_cnt_q[ba] < RCD5)      viol[3]  = 1'b1;
            if (a10)                       viol[12] = 1'b1;
            if (cmd == CMD_WR) begin
               mem_we = 1'b1;
               if (oe_q) viol[9] = 1'b1;
            end else if (cl3_q) begin
               rd_v_d[1]    = 1'b1;
               rd_data_d[1] = mem_rd;
            end else begin
               rd_v_d[0]    = 1'b1;
               rd_data_d[0] = mem_rd;
            end
         end
         default: ;
      endcase

`ifdef SDRAM_RESP_REFRESH_CHECK_EN
      ri_run_d = ri_run_q;
      ri_cnt_d = (ri_cnt_q == 16'hFFFF) ? ri_cnt_q : ri_cnt_q + 16'd1;
      if (cmd == CMD_REF) begin
         ri_cnt_d = '0;
         if (mode_set_q) ri_run_d = 1'b1;
      end else if (ri_run_q && ri_cnt_q == RI_LAST) begin
         viol[11] = 1'b1;
      end
`endif

      first = '0;
      for (int i = 15; i >= 1; i--) begin
         if (viol[i]) first = 4'(i);
      end
      err_d  = err_q;
      code_d = code_q;
      if (!err_q && viol != '0) begin
         err_d  = 1'b1;
         code_d = first;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int b = 0; b < NB; b++) begin
            bank_q[b]    <= BANK_IDLE;
            row_q[b]     <= '0;
            act_cnt_q[b] <= 5'd31;
            pre_cnt_q[b] <= 5'd31;
         end
         mrd_cnt_q    <= 5'd31;
         ref_cnt_q    <= 5'd31;
         mode_set_q   <= 1'b0;
         cl3_q        <= 1'b1;
         rd_v_q       <= '0;
         rd_data_q[0] <= '0;
         rd_data_q[1] <= '0;
         data_o_q     <= '0;
         oe_q         <= 1'b0;
         err_q        <= 1'b0;
         code_q       <= '0;
`ifdef SDRAM_RESP_REFRESH_CHECK_EN
         ri_cnt_q     <= '0;
         ri_run_q     <= 1'b0;
`endif
      end else begin
         bank_q     <= bank_d;
         row_q      <= row_d;
         act_cnt_q  <= act_cnt_d;
         pre_cnt_q  <= pre_cnt_d;
         mrd_cnt_q  <= mrd_cnt_d;
         ref_cnt_q  <= ref_cnt_d;
         mode_set_q <= mode_set_d;
         cl3_q      <= cl3_d;
         rd_v_q     <= rd_v_d;
         rd_data_q  <= rd_data_d;
         data_o_q   <= data_o_d;
         oe_q       <= oe_d;
         err_q      <= err_d;
         code_q     <= code_d;
`ifdef SDRAM_RESP_REFRESH_CHECK_EN
         ri_cnt_q   <= ri_cnt_d;
         ri_run_q   <= ri_run_d;
`endif
      end
   end

   // Storage is deliberately left uninitialised across reset.
   always_ff @(posedge clk) begin
      if (!reset && mem_we) mem_q[mem_idx] <= bus.pin_data_i;
   end

   always_comb begin
      for (int b = 0; b < NB; b++) dbg_bank_active_o[b] = (bank_q[b] == BANK_ACTIVE);
   end

   assign bus.pin_data_o  = data_o_q;
   assign bus.pin_data_oe = oe_q;
   assign err             = err_q;
   assign err_code        = code_q;
endmodule

// File: tb/tb_sdram_responder.sv
// Directed bench for sdram_responder: init sequence, CL3/CL2 reads, error codes, reset mid-read.
module tb_sdram_responder;
   localparam int AW = 12;
   localparam logic [2:0] C_MODE = 3'b000, C_REF = 3'b001, C_PRE = 3'b010, C_ACT = 3'b011;
   localparam logic [2:0] C_WR = 3'b100, C_RD = 3'b101, C_NOP = 3'b111;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       err;
   logic [3:0] err_code;
   logic [1:0] dbg;
   int         n_checks = 0;
   int         n_fail = 0;

   sdram_if #(.AW(AW), .DWIDTH(16)) bus ();

   sdram_responder #(
      .T_RCD(3)
`ifdef SDRAM_RESP_REFRESH_CHECK_EN
      , .T_RI_MAX(64)
`endif
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .bus              (bus),
      .err              (err),
      .err_code         (err_code),
      .dbg_bank_active_o(dbg)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [AW-1:0] adr(input logic b, input logic [10:0] a);
      return {b, a};
   endfunction

   // Drives one command for one rising edge, then returns #1 after that edge with NOP on the pins.
   task automatic cmd(input logic [2:0] c, input logic [AW-1:0] a, input logic [15:0] d);
      {bus.pin_ras_n, bus.pin_cas_n, bus.pin_we_n} = c;
      bus.pin_addr   = a;
      bus.pin_data_i = d;
      @(posedge clk);
      #1;
      {bus.pin_ras_n, bus.pin_cas_n, bus.pin_we_n} = C_NOP;
      bus.pin_addr   = '0;
      bus.pin_data_i = '0;
   endtask

   task automatic nop(input int n);
      repeat (n) cmd(C_NOP, '0, '0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      nop(2);
      reset = 1'b0;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic mode_ok(input logic [AW-1:0] m);
      cmd(C_MODE, m, '0);
      nop(2);
   endtask

   initial begin
      {bus.pin_ras_n, bus.pin_cas_n, bus.pin_we_n} = C_NOP;
      bus.pin_addr   = '0;
      bus.pin_data_i = '0;
      do_reset();
      check("rst_oe", bus.pin_data_oe, 0);
      check("rst_data", bus.pin_data_o, 0);
      check("rst_err", err, 0);
      check("rst_code", err_code, 0);
      check("rst_banks", dbg, 0);

      // Init: precharge all, CL3 mode, two refreshes, then write/read bank0 row5 col3.
      cmd(C_PRE, adr(0, 11'h400), '0);
      nop(2);
      mode_ok(12'h030);
      cmd(C_REF, '0, '0);
      nop(7);
      cmd(C_REF, '0, '0);
      nop(7);
      cmd(C_ACT, adr(0, 11'd5), '0);
      nop(2);
      cmd(C_WR, adr(0, 11'd3), 16'hBEEF);
      cmd(C_RD, adr(0, 11'd3), '0);
      check("cl3_e0_oe", bus.pin_data_oe, 0);
      nop(1);
      check("cl3_e1_oe", bus.pin_data_oe, 0);
      nop(1);
      check("cl3_e2_oe", bus.pin_data_oe, 1);
      check("cl3_e2_data", bus.pin_data_o, 16'hBEEF);
      nop(1);
      check("cl3_e3_oe", bus.pin_data_oe, 0);
      check("init_err", err, 0);
      check("init_banks", dbg, 2'b01);

      // CL2 streaming of four words.
      cmd(C_WR, adr(0, 11'd0), 16'h1111);
      cmd(C_WR, adr(0, 11'd1), 16'h2222);
      cmd(C_WR, adr(0, 11'd2), 16'h3333);
      cmd(C_WR, adr(0, 11'd3), 16'h4444);
      mode_ok(12'h020);
      cmd(C_RD, adr(0, 11'd0), '0);
      check("cl2_e0_oe", bus.pin_data_oe, 0);
      cmd(C_RD, adr(0, 11'd1), '0);
      check("cl2_w0", {15'd0, bus.pin_data_oe, bus.pin_data_o}, {16'd1, 16'h1111});
      cmd(C_RD, adr(0, 11'd2), '0);
      check("cl2_w1", {15'd0, bus.pin_data_oe, bus.pin_data_o}, {16'd1, 16'h2222});
      cmd(C_RD, adr(0, 11'd3), '0);
      check("cl2_w2", {15'd0, bus.pin_data_oe, bus.pin_data_o}, {16'd1, 16'h3333});
      nop(1);
      check("cl2_w3", {15'd0, bus.pin_data_oe, bus.pin_data_o}, {16'd1, 16'h4444});
      nop(1);
      check("cl2_end_oe", bus.pin_data_oe, 0);
      check("cl2_err", err, 0);

      // tRCD violation, then a tRP violation must not replace the first code.
      cmd(C_ACT, adr(1, 11'd7), '0);
      nop(1);
      cmd(C_RD, adr(1, 11'd0), '0);
      check("trcd_err", err, 1);
      check("trcd_code", err_code, 3);
      nop(1);
      cmd(C_PRE, adr(1, 11'd0), '0);
      cmd(C_ACT, adr(1, 11'd7), '0);
      check("trp_sticky_code", err_code, 3);
      check("trp_banks", dbg, 2'b11);

      do_reset();
      cmd(C_ACT, adr(0, 11'd5), '0);
      check("premode_code", err_code, 1);

      do_reset();
      cmd(C_MODE, 12'h050, '0);
      check("badmode_code", err_code, 10);

      do_reset();
      cmd(C_MODE, 12'h030, '0);
      cmd(C_PRE, adr(0, 11'h400), '0);
      check("tmrd_code", err_code, 8);

      do_reset();
      mode_ok(12'h030);
      cmd(C_WR, adr(1, 11'd0), 16'h5555);
      check("idle_wr_err", err, 1);
      check("idle_wr_code", err_code, 2);

      do_reset();
      mode_ok(12'h030);
      cmd(C_ACT, adr(0, 11'd5), '0);
      check("act_ok_err", err, 0);
      nop(2);
      cmd(C_REF, '0, '0);
      check("ref_active_code", err_code, 7);

      // Bus conflict: array survives reset, write during oe still lands.
      do_reset();
      mode_ok(12'h030);
      cmd(C_ACT, adr(0, 11'd5), '0);
      nop(2);
      cmd(C_RD, adr(0, 11'd3), '0);
      nop(2);
      check("retain_data", {15'd0, bus.pin_data_oe, bus.pin_data_o}, {16'd1, 16'h4444});
      check("retain_err", err, 0);
      cmd(C_WR, adr(0, 11'd3), 16'hCAFE);
      check("conflict_code", err_code, 9);
      cmd(C_RD, adr(0, 11'd3), '0);
      nop(2);
      check("conflict_data", {15'd0, bus.pin_data_oe, bus.pin_data_o}, {16'd1, 16'hCAFE});

      // Reset arriving one edge after a READ drops the pending word.
      cmd(C_RD, adr(0, 11'd3), '0);
      reset = 1'b1;
      nop(1);
      check("midrst_oe", bus.pin_data_oe, 0);
      check("midrst_code", err_code, 0);
      check("midrst_banks", dbg, 0);
      reset = 1'b0;
      nop(1);
      check("midrst_drop_oe", bus.pin_data_oe, 0);
      check("midrst_drop_data", bus.pin_data_o, 0);

      // Refresh interval: gap 60 is fine, gap of 64+ raises code 11 when the check is built in.
      do_reset();
      mode_ok(12'h030);
      cmd(C_REF, '0, '0);
      nop(59);
      cmd(C_REF, '0, '0);
      check("ri_gap60_err", err, 0);
      nop(63);
      check("ri_63_err", err, 0);
      nop(1);
`ifdef SDRAM_RESP_REFRESH_CHECK_EN
      check("ri_64_err", err, 1);
      check("ri_64_code", err_code, 11);
`else
      check("ri_off_err", err, 0);
      nop(6);
      check("ri_off_code", err_code, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
